// File: rtl/matrix_pkg.sv
// Shared types and constants for the 3x3 matrix multiplier datapath.
// Used by the multiplier, the input loader and the result streamer.
package matrix_pkg;

    localparam int ELEM_W = 16;
    localparam int N_ELEM = 9;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        CHKSUM
    } stream_state_t;

    // Row-major flat index of element (row, col) in a packed 3x3 matrix.
    function automatic logic [3:0] elem_idx(input logic [1:0] row, input logic [1:0] col);
        return 4'(row) * 4'd3 + 4'(col);
    endfunction

endpackage

// File: rtl/matrix_result_streamer.sv
// Captures a packed 3x3 result and streams it out one element per valid/ready beat.
// Optional trailing checksum beat when CHKSUM_EN is defined.
//
// state  | meaning
// IDLE   | no matrix held, waiting for load
// STREAM | presenting element[idx]
// CHKSUM | presenting the wrapped element sum (CHKSUM_EN only)
module matrix_result_streamer
    import matrix_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic [ELEM_W*N_ELEM-1:0]   c_in,
    output logic [ELEM_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy,
    output logic                       overrun
);

    localparam logic [3:0] LAST_IDX = 4'(N_ELEM - 1);

    stream_state_t              state;
    stream_state_t              state_next;
    logic [ELEM_W*N_ELEM-1:0]   buffer;
    logic [3:0]                 idx;
    logic                       finish;
    logic                       accept;

`ifdef CHKSUM_EN
    logic [ELEM_W-1:0] chksum;
    logic [ELEM_W-1:0] sum_in;

    always_comb begin
        sum_in = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                sum_in = sum_in + c_in[ELEM_W*elem_idx(2'(r), 2'(c)) +: ELEM_W];
            end
        end
    end
`endif

    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = '0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (load) state_next = STREAM;
            end
            STREAM: begin
                out_valid = 1'b1;
                out_data  = buffer[ELEM_W*idx +: ELEM_W];
`ifdef CHKSUM_EN
                if (out_ready && idx == LAST_IDX) state_next = CHKSUM;
`else
                out_last = (idx == LAST_IDX);
                if (out_ready && idx == LAST_IDX) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
`endif
            end
`ifdef CHKSUM_EN
            CHKSUM: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = chksum;
                if (out_ready) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
        // A load coinciding with the finishing transfer chains straight into the next matrix.
        if (finish && load) state_next = STREAM;
        accept = load && (state == IDLE || finish);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            buffer  <= '0;
            idx     <= '0;
            overrun <= 1'b0;
`ifdef CHKSUM_EN
            chksum  <= '0;
`endif
        end else begin
            state   <= state_next;
            overrun <= load && !accept;
            if (accept) begin
                buffer <= c_in;
                idx    <= '0;
`ifdef CHKSUM_EN
                chksum <= sum_in;
`endif
            end else if (state == STREAM && out_ready && idx != LAST_IDX) begin
                idx <= idx + 4'd1;
            end
        end
    end

endmodule

// File: doc/matrix_result_streamer.md
# matrix_result_streamer

Downstream stage of the 3x3 matrix multiplier. Captures the packed 144-bit result matrix when the multiplier signals completion, then streams the nine 16-bit elements out one per beat over a valid/ready handshake, in row-major order. It decouples the multiplier from a narrow, back-pressured consumer such as a UART or bus bridge.

## Interface
- ELEM_W, 16, width of one result element in bits
- N_ELEM, 9, number of elements per matrix
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- load  in  1  single-cycle capture strobe; driven by the multiplier's done
- c_in  in  ELEM_W*N_ELEM  packed result; element e = c_in[ELEM_W*e +: ELEM_W], e = row*3 + col
- out_data  out  ELEM_W  current beat data
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts beat
- out_last  out  1  high on the final beat of a matrix
- busy  out  1  a captured matrix is not yet fully transferred
- overrun  out  1  one-cycle pulse when load is rejected

## Operation
- States: IDLE, STREAM, and CHKSUM (CHKSUM exists only with the macro).
- IDLE, load=1: register c_in into an internal buffer; set the beat index to 0; go to STREAM.
- STREAM: out_valid=1; out_data = buffer element[index]. A transfer occurs when out_valid && out_ready.
  - On transfer with index<8: index++.
  - On transfer with index==8: go to CHKSUM if enabled, otherwise finish.
- Finish: next state IDLE, out_valid=0, busy=0.
- Back-to-back: load=1 in the same cycle as the finishing transfer is accepted. The new matrix is captured, the state goes or stays in STREAM with index 0, and out_valid stays high with no gap.
- load=1 while busy, other than at the finishing transfer: the load is ignored. overrun pulses high for 1 cycle. The buffer and the stream in progress are unaffected.
- out_data, out_last and out_valid must hold stable while out_valid && !out_ready.
- out_last = 1 on beat index 8 when the macro is undefined, and on the CHKSUM beat when it is defined.
- busy = (state != IDLE).
- Reset values: out_data=0, out_valid=0, out_last=0, busy=0, overrun=0, state IDLE, index 0, buffer 0.
- Reset asserted mid-stream aborts the matrix immediately. No further beats are produced after release.

## Timing
- load sampled at edge t: out_valid=1 with element 0 from t+1.
- With out_ready held high: element e is presented in cycle t+1+e. out_last is in cycle t+9, or t+10 with the checksum. busy falls in the cycle after the last transfer.
- Throughput: 1 beat per cycle; no bubbles within a matrix or between back-to-back matrices.
- overrun: asserted in the cycle after the rejected load, for exactly 1 cycle.

## Configuration
- CHKSUM_EN defined:
  - At capture, also register the sum of all nine elements, truncated to ELEM_W bits (wraps mod 2^ELEM_W).
  - After element 8 transfers, enter CHKSUM and present the sum as a 10th beat with out_last=1.
  - Finish on transfer of that beat.
- CHKSUM_EN undefined:
  - Nine beats per matrix; there is no checksum register or state.

## Structure
- Shared package matrix_pkg holds:
  - ELEM_W and N_ELEM constants.
  - The streamer state enum (IDLE, STREAM, CHKSUM).
  - The element index helper (row*3 + col).
- The multiplier and the future input loader reuse the same package.
- No sub-module. The buffer, 4-bit index counter, checksum adder and FSM fit naturally in one module.

## Test plan
- c_in elements 1..9 (element e = e+1), load pulse, out_ready=1 → out_data 1,2,…,9 on consecutive cycles from t+1; out_last only with 9; busy low at t+10.
- Same load; out_ready low for 3 cycles while element 4 (value 5) is presented → out_data holds 5 with valid high; the sequence then resumes 6..9 with nothing skipped or duplicated.
- Second load asserted while beat 3 is pending → overrun pulses for 1 cycle; the stream continues 4..9 from the original matrix.
- New matrix (all 0x0010) loaded in the same cycle as the final transfer → the next cycle shows out_valid=1, out_data=0x0010, out_last=0; 9 more beats follow.
- Reset asserted after 3 transfers → all outputs go to 0 immediately; after release with no load, out_valid stays 0.
- CHKSUM_EN, all elements 0xFFFF → 9 beats of 0xFFFF, then a 10th beat of 0xFFF7 with out_last=1.
